i2s_tx_serializer: RTL and testbench

- Transmit-side counterpart of the downsampler's I2S-style input: takes parallel 32-bit left/right words and serialises them as bit clock (obick), word clock (olrck) and serial data (osdata).
- Everything is generated from the master clock pclk, nominally 45.1584 MHz, giving 64 bits per frame.
- Sits after the down-rate datapath (e.g. the 44.1 kHz CIC output) and drives an external DAC or codec.
- Parallel words enter through a valid/ready handshake into a single holding buffer.

---
 rtl/i2s_tx_serializer_if.sv | 11 +
 rtl/i2s_tx_serializer.sv | 85 ++++++++
 tb/tb_i2s_tx_serializer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/i2s_tx_serializer_if.sv
// i2s_tx_serializer_if: valid/ready handshake carrying one left/right sample pair
interface i2s_tx_serializer_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] ldata;
    logic [WORD_W-1:0] rdata;
    modport master (output in_valid, ldata, rdata, input in_ready);
    modport slave (input in_valid, ldata, rdata, output in_ready);
endinterface

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: parallel L/R words to obick/olrck/osdata; I2S timing by default, left-justified with I2S_TX_LJ_FORMAT_EN
module i2s_tx_serializer #(
    parameter int BCK_DIV = 8,
    parameter int WORD_W  = 32
) (
    input  logic               pclk,
    input  logic               reset_n,
    i2s_tx_serializer_if.slave bus,
    output logic               obick,
    output logic               olrck,
    output logic               osdata,
    output logic               frame_start,
    output logic               underrun
);
    localparam int DW = $clog2(BCK_DIV);
    localparam int BW = $clog2(2 * WORD_W);

    logic [DW-1:0]       div_cnt;
    logic [BW-1:0]       bit_cnt, bit_nxt, pos;
    logic [WORD_W-1:0]   hold_l, hold_r, act_l, act_r, nxt_l, nxt_r;
    logic [2*WORD_W-1:0] frame;
    logic                hold_full, fall, load, xfer, wrap;

    assign bus.in_ready = !hold_full;

    // fall-event detection, frame load and the {L,R} bit position played in the new slot
    always_comb begin
        wrap    = div_cnt == DW'(BCK_DIV - 1);
        fall    = obick && wrap;
        bit_nxt = bit_cnt + BW'(1);
`ifdef I2S_TX_LJ_FORMAT_EN
        load    = fall && bit_nxt == '0;
        pos     = ~bit_nxt;
`else
        load    = fall && bit_nxt == BW'(1);
        pos     = -bit_nxt;
`endif
        xfer    = bus.in_valid && !hold_full;
        nxt_l   = load ? (hold_full ? hold_l : '0) : act_l;
        nxt_r   = load ? (hold_full ? hold_r : '0) : act_r;
        frame   = {nxt_l, nxt_r};
    end

    // bit clock divider and serial outputs; serial state moves only on obick falling edges
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            obick       <= 1'b0;
            bit_cnt     <= '1;
            olrck       <= 1'b0;
            osdata      <= 1'b0;
            act_l       <= '0;
            act_r       <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            div_cnt     <= wrap ? '0 : div_cnt + DW'(1);
            obick       <= wrap ? !obick : obick;
            frame_start <= load;
            underrun    <= load && !hold_full;
            act_l       <= nxt_l;
            act_r       <= nxt_r;
            if (fall) begin
                bit_cnt <= bit_nxt;
                olrck   <= bit_nxt[BW-1];
                osdata  <= frame[pos];
            end
        end
    end

    // single-entry holding buffer; a load in the same cycle as a transfer still sees it empty
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else begin
            hold_full <= xfer ? 1'b1 : load ? 1'b0 : hold_full;
            if (xfer) begin
                hold_l <= bus.ldata;
                hold_r <= bus.rdata;
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: randomized check of i2s_tx_serializer against a cycle-count frame model
module tb_i2s_tx_serializer;
    localparam int BCK_DIV   = 8;
    localparam int WORD_W    = 32;
    localparam int FRAME_CYC = 2 * BCK_DIV * 2 * WORD_W;
`ifdef I2S_TX_LJ_FORMAT_EN
    localparam int LOAD_N = 0;
    localparam int LOAD_K = 1;
    localparam int CAP_K  = 64;
    localparam logic [63:0] EXP_CAP = 64'h7FFFFFFE_80000001;
`else
    localparam int LOAD_N = 1;
    localparam int LOAD_K = 2;
    localparam int CAP_K  = 65;
    localparam logic [63:0] EXP_CAP = 64'hFFFFFFFD_00000002;
`endif

    logic pclk = 1'b0;
    logic reset_n = 1'b0;
    logic obick, olrck, osdata, frame_start, underrun;

    i2s_tx_serializer_if #(.WORD_W(WORD_W)) bus ();

    i2s_tx_serializer #(.BCK_DIV(BCK_DIV), .WORD_W(WORD_W)) dut (
        .pclk(pclk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .obick(obick),
        .olrck(olrck),
        .osdata(osdata),
        .frame_start(frame_start),
        .underrun(underrun)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc, k, n, loads, xfers, ur_cnt, first_fall, guard;
    logic hold_full_m, last_xfer, prev_bick;
    logic [31:0] hold_l_m, hold_r_m, act_l_m, act_r_m, pat;
    logic e_bick, e_lrck, e_sd, e_fs, e_ur;
    logic [63:0] cap;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic bit_of(input logic [31:0] l, input logic [31:0] r, input int idx);
`ifdef I2S_TX_LJ_FORMAT_EN
        return idx < 32 ? l[31-idx] : r[63-idx];
`else
        if (idx == 0) return r[0];
        if (idx <= 32) return l[32-idx];
        return r[64-idx];
`endif
    endfunction

    task automatic model_reset();
        cyc = 0; k = 0; n = 63;
        hold_full_m = 1'b0; hold_l_m = '0; hold_r_m = '0; act_l_m = '0; act_r_m = '0;
        e_bick = 1'b0; e_lrck = 1'b0; e_sd = 1'b0; e_fs = 1'b0; e_ur = 1'b0;
        prev_bick = 1'b0; last_xfer = 1'b0;
    endtask

    task automatic compare_all();
        check("obick", obick, e_bick);
        check("olrck", olrck, e_lrck);
        check("osdata", osdata, e_sd);
        check("frame_start", frame_start, e_fs);
        check("underrun", underrun, e_ur);
        check("in_ready", bus.in_ready, !hold_full_m);
    endtask

    task automatic tick();
        logic v;
        logic [31:0] l, r;
        @(posedge pclk);
        v = bus.in_valid; l = bus.ldata; r = bus.rdata;
        @(negedge pclk);
        last_xfer = v && !hold_full_m;
        cyc++;
        e_bick = ((cyc / BCK_DIV) % 2) == 1;
        e_fs = 1'b0;
        e_ur = 1'b0;
        if (cyc % (2 * BCK_DIV) == 0) begin
            k++;
            n = (n + 1) % 64;
            e_lrck = n >= 32;
            if (n == LOAD_N) begin
                e_fs = 1'b1;
                if (hold_full_m) begin
                    act_l_m = hold_l_m; act_r_m = hold_r_m; hold_full_m = 1'b0;
                end else begin
                    act_l_m = '0; act_r_m = '0; e_ur = 1'b1;
                end
            end
            e_sd = bit_of(act_l_m, act_r_m, n);
            if (k <= CAP_K) cap[n] = osdata;
        end
        if (last_xfer) begin
            hold_l_m = l; hold_r_m = r; hold_full_m = 1'b1; xfers++;
        end
        if (e_fs) loads++;
        if (underrun) ur_cnt++;
        if (prev_bick && !obick && first_fall == 0) first_fall = cyc;
        prev_bick = obick;
        compare_all();
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.ldata = '0; bus.rdata = '0;
        model_reset();
        loads = 0; xfers = 0; ur_cnt = 0; first_fall = 0; cap = '0;
        repeat (3) @(negedge pclk);
        compare_all();
        reset_n = 1'b1;

        bus.in_valid = 1'b1; bus.ldata = 32'h80000001; bus.rdata = 32'h7FFFFFFE;
        tick();
        bus.in_valid = 1'b0;
        repeat (66 * 2 * BCK_DIV) tick();
        check("first_fall_cyc", first_fall, 2 * BCK_DIV);
        check("frame1_bits", cap, EXP_CAP);

        pat = 32'h1; ur_cnt = 0; xfers = 0; loads = 0;
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            bus.in_valid = 1'b1; bus.ldata = pat; bus.rdata = ~pat;
            tick();
            if (last_xfer) pat++;
        end
        check("cont_underruns", ur_cnt, 0);
        check("cont_xfers", xfers, loads + 1);

        guard = 0;
        while (!hold_full_m && guard < FRAME_CYC) begin
            tick(); guard++;
        end
        bus.in_valid = 1'b0; ur_cnt = 0; loads = 0; guard = 0;
        while (loads < 3 && guard < 4 * FRAME_CYC) begin
            tick(); guard++;
        end
        check("idle_underruns", ur_cnt, 2);

        guard = 0;
        while (!(n == 40 && hold_full_m) && guard < 3 * FRAME_CYC) begin
            bus.in_valid = 1'b1; bus.ldata = pat; bus.rdata = pat ^ 32'hA5A5A5A5;
            tick(); guard++;
            if (last_xfer) pat++;
        end
        check("rst_pre_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_obick", obick, 0);
        check("rst_olrck", olrck, 0);
        check("rst_osdata", osdata, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_underrun", underrun, 0);
        check("rst_in_ready", bus.in_ready, 1);
        model_reset();
        repeat (2) begin
            @(negedge pclk);
            compare_all();
        end
        reset_n = 1'b1;
        guard = 0;
        while (!e_fs && guard < 2 * FRAME_CYC) begin
            tick(); guard++;
        end
        check("post_rst_underrun", underrun, 1);
        check("post_rst_load_k", k, LOAD_K);

        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < FRAME_CYC; i++) begin
                bus.in_valid = f < 6 ? ($urandom_range(0, 299) == 0) : ($urandom_range(0, 2999) == 0);
                bus.ldata = $urandom;
                bus.rdata = $urandom;
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
